bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter that uses the shift-and-add-3 (double dabble) method. It turns a binary result into decimal digits that the seven-segment driver path can display. It replaces combinational divide chains in the top-level FSM's result/done state. The top FSM pulses start with the binary value; the block returns packed BCD digits with a one-cycle done pulse.

Parameters:
BIN_W, 14, width of the binary input.
DIGITS, 4, number of BCD output digits; the maximum representable value is 10^DIGITS-1 (9999 by default).

Ports:
clk  input  1  system clock (CLK100MHZ domain).
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
bin  input  BIN_W  binary value; sampled on the accepted start cycle.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse when bcd and overflow are valid.
overflow  output  1  set if the latched bin exceeded 10^DIGITS-1; held until the next done.
bcd  output  4*DIGITS  packed digits; [3:0] is ones, [7:4] tens, and so on; held until the next done.

Behaviour:
- Reset (reset low, async) forces the following, regardless of state:
  - state=IDLE; busy=0, done=0, overflow=0, bcd=0.
  - Internal shift register and counter are cleared.
- States:
  - IDLE -> SHIFT on start=1.
  - SHIFT -> DONE after BIN_W iterations.
  - DONE -> IDLE unconditionally after 1 cycle.
- IDLE, on start=1:
  - Latch bin into the shift register.
  - Clear the BCD accumulator (4*DIGITS+4 bits internally, one guard digit).
  - Load the iteration counter with BIN_W.
  - Latch ovf_pending = (bin > 10^DIGITS-1), unsigned compare.
- SHIFT, once per cycle:
  - Every accumulator digit >= 5 gets +3.
  - Then {accumulator, shift register} shifts left by 1.
  - The counter decrements; leave SHIFT when the counter reaches 0.
- DONE:
  - done=1 for exactly this cycle.
  - bcd and overflow registers update on entry to this cycle, i.e. they are valid while done=1.
  - If ovf_pending: bcd = all digits 9, overflow=1.
  - Else: bcd = low 4*DIGITS bits of the accumulator, overflow=0.
- Latency:
  - start accepted at cycle 0; done=1 at cycle BIN_W+1 (15 by default).
  - busy=1 from cycle 1 through BIN_W+1 inclusive.
  - Next start can be accepted at cycle BIN_W+2.
- Rules and boundaries:
  - start while busy=1 (SHIFT or DONE) is ignored; no queueing, and bin changes during busy have no effect.
  - Reset asserted mid-conversion aborts it: no done pulse, and bcd returns to 0.
  - bin=0 gives bcd=0, overflow=0, with the full latency (no early exit).
  - The 10^DIGITS-1 bound is evaluated at elaboration as a constant of width BIN_W+1; no runtime division.
  - Guard digit: its content is discarded; overflow comes only from ovf_pending.
  - Outputs are all registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package bcd_pkg:
  - State encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - Constant function pow10(n) for the max-value bound.
  - Default BIN_W/DIGITS constants so the top and the SS driver path agree on digit count.
- One natural sub-module: bcd_digit_adj.
  - 4-bit combinational block: out = (in >= 5) ? in+3 : in.
  - Instantiated DIGITS+1 times via generate.

Test Plan:
- Convert 0: start with bin=0 -> done exactly 15 cycles after start, bcd=16'h0000, overflow=0; busy high for 15 cycles.
- Convert 1234: bin=1234 -> bcd=16'h1234, overflow=0; then bin=9999 -> bcd=16'h9999, overflow=0.
- Overflow: bin=10000 -> bcd=16'h9999, overflow=1. Next convert of bin=7 -> bcd=16'h0007, overflow=0.
- Ignored start: bin=42 accepted, then start with bin=5000 pulsed at cycle 5 and again in the DONE cycle -> single done, bcd=16'h0042, no second conversion.
- Reset mid-op: bin=9876 started, reset low at cycle 8 for 2 cycles -> no done pulse, bcd=0, busy=0. Subsequent start with bin=9876 -> bcd=16'h9876 at latency 15.
- Back-to-back: start at cycle 16 (the first IDLE cycle after the previous done) with bin=16383 -> accepted, overflow=1, bcd=16'h9999.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the binary-to-BCD converter and the seven-segment path.
// It holds the FSM encoding, the default widths and the decimal bound helper.
package bcd_pkg;

  localparam int BIN_W_DEF  = 14;
  localparam int DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Used only at elaboration to size the overflow bound.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the top-level FSM (master) and the converter (slave).
// The master pulses start with bin while busy=0. The slave answers with a one-cycle done,
// and bcd/overflow stay valid from done until the next done.
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, bin,
    input  busy, done, overflow, bcd
  );

  modport slave (
    input  start, bin,
    output busy, done, overflow, bcd
  );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj (
  input  logic [3:0] value,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = (value >= 4'd5) ? 4'(value + 4'd3) : value;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with a fixed latency of BIN_W+1 cycles.
// An input above 10^DIGITS-1 saturates to all nines and raises overflow.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  bin_to_bcd_seq_if.slave bus,
  output state_t          state_dbg
);

  localparam int ACC_W = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W:0] MAX_VAL = (BIN_W+1)'(pow10(DIGITS) - 1);

  state_t               state, state_nxt;
  logic [BIN_W-1:0]     shreg;
  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_pending;
  logic [4*DIGITS-1:0]  bcd_q;
  logic                 overflow_q;

  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W+BIN_W-1:0] shifted;
  logic                   accept;
  logic                   last_shift;

  // One corrector per digit, including the guard digit.
  for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .value    (acc[4*g +: 4]),
      .adjusted (acc_adj[4*g +: 4])
    );
  end

  assign shifted    = {acc_adj, shreg} << 1;
  assign accept     = (state == IDLE) && bus.start;
  assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE);
    bus.bcd      = bcd_q;
    bus.overflow = overflow_q;
    state_dbg    = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg       <= '0;
      acc         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
    end else if (accept) begin
      shreg       <= bus.bin;
      acc         <= '0;
      cnt         <= CNT_W'(BIN_W);
      ovf_pending <= ({1'b0, bus.bin} > MAX_VAL);
    end else if (state == SHIFT) begin
      acc   <= shifted[ACC_W+BIN_W-1:BIN_W];
      shreg <= shifted[BIN_W-1:0];
      cnt   <= cnt - CNT_W'(1);
    end
  end

  // Result registers load on the final shift so they are valid in the DONE cycle.
  // The guard digit is dropped; overflow comes only from the latched range check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else if (last_shift) begin
      if (ovf_pending) begin
        bcd_q      <= {DIGITS{4'h9}};
        overflow_q <= 1'b1;
      end else begin
        bcd_q      <= shifted[ACC_W+BIN_W-5:BIN_W];
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, conversion values, overflow saturation,
// ignored starts, mid-conversion reset and back-to-back requests.
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = BIN_W + 1;

  logic   clk;
  logic   reset;
  state_t state_dbg;
  int     checks;
  int     errors;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start at the current cycle, wait for done and check latency, result and release.
  task automatic convert(input string tag, input logic [BIN_W-1:0] value,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat;
    bus.start = 1'b1;
    bus.bin   = value;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk({tag, "_done_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_bcd_hold"}, 32'(bus.bcd), 32'(exp_bcd));
  endtask

  initial begin
    int seen;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_bcd", 32'(bus.bcd), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b1;
    tick();

    convert("zero", 14'd0, 16'h0000, 1'b0);
    convert("c1234", 14'd1234, 16'h1234, 1'b0);
    convert("c9999", 14'd9999, 16'h9999, 1'b0);
    convert("c10000", 14'd10000, 16'h9999, 1'b1);
    convert("c7", 14'd7, 16'h0007, 1'b0);

    // Starts during SHIFT and DONE must be dropped.
    bus.start = 1'b1;
    bus.bin   = 14'd42;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ign_shift_state", 32'(state_dbg), 32'(SHIFT));
    bus.start = 1'b1;
    bus.bin   = 14'd5000;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("ign_done", 32'(bus.done), 32'd1);
    chk("ign_bcd", 32'(bus.bcd), 32'h0042);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign_idle", 32'(bus.busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk("ign_no_second", 32'(seen), 32'd0);
    chk("ign_bcd_hold", 32'(bus.bcd), 32'h0042);

    // Reset in the middle of a conversion.
    bus.start = 1'b1;
    bus.bin   = 14'd9876;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b0;
    #1;
    chk("rmid_busy", 32'(bus.busy), 32'd0);
    chk("rmid_done", 32'(bus.done), 32'd0);
    chk("rmid_bcd", 32'(bus.bcd), 32'd0);
    chk("rmid_state", 32'(state_dbg), 32'(IDLE));
    tick();
    tick();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    chk("rmid_no_done", 32'(seen), 32'd0);
    chk("rmid_bcd_after", 32'(bus.bcd), 32'd0);
    convert("c9876", 14'd9876, 16'h9876, 1'b0);

    // convert() returns in the first IDLE cycle, so this start is back-to-back.
    convert("b2b_16383", 14'd16383, 16'h9999, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
